// File: rtl/iot_riscv_regfile_sb_pkg.sv
// Shared constants for the iot_riscv integer register file and its
// outstanding-write scoreboard.
package iot_riscv_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int REG_SLOTS   = 1 << REG_IDX_W;
  localparam int NREGS_RV32E = 16;
  localparam int NREGS_RV32I = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t X0_IDX = '0;

  // True for an index that names a real, writable architectural register.
  function automatic logic idx_live(reg_idx_t idx, int nregs);
    return (idx != X0_IDX) && (int'(idx) < nregs);
  endfunction

endpackage

// File: rtl/iot_riscv_regfile_sb_if.sv
// Decode / issue / writeback / debug bundle of the register file.
// slave = register file side, master = pipeline side.
interface iot_riscv_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  import iot_riscv_pkg::*;

  logic                     id_ready_i;
  logic                     id_flush_i;
  logic [NRP*REG_IDX_W-1:0] id_rs_index_i;
  logic [NRP*XLEN-1:0]      id_rs_value_o;
  logic                     id_stall_o;
  logic                     id_illegal_o;
  logic                     iss_valid_i;
  reg_idx_t                 iss_rd_index_i;
  logic                     iss_full_o;
  logic                     wb_we_i;
  reg_idx_t                 wb_index_i;
  logic [XLEN-1:0]          wb_value_i;
  logic                     sb_err_o;
  logic [NREGS*XLEN-1:0]    dbg_reg_o;

  modport slave (
    input  id_ready_i, id_flush_i, id_rs_index_i,
           iss_valid_i, iss_rd_index_i,
           wb_we_i, wb_index_i, wb_value_i,
    output id_rs_value_o, id_stall_o, id_illegal_o,
           iss_full_o, sb_err_o, dbg_reg_o
  );

  modport master (
    output id_ready_i, id_flush_i, id_rs_index_i,
           iss_valid_i, iss_rd_index_i,
           wb_we_i, wb_index_i, wb_value_i,
    input  id_rs_value_o, id_stall_o, id_illegal_o,
           iss_full_o, sb_err_o, dbg_reg_o
  );

endinterface

// File: rtl/iot_riscv_regfile_sb_cnt.sv
// Saturating pending-write counter for one register: counts issues up,
// writebacks down, and flags a writeback that arrives with nothing pending.
module iot_riscv_regfile_sb_cnt #(
  parameter int PENDW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  output logic [PENDW-1:0] cnt,
  output logic             full,
  output logic             uflow
);
  logic empty, up, dn;

  assign empty = (cnt == '0);
  assign full  = (cnt == '1);
  assign uflow = dec & empty;
  assign up    = inc & ~full;
  assign dn    = dec & ~empty;

  // up & dn together cancel: the issue and the retire refer to different writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           cnt <= '0;
    else if (up & ~dn)   cnt <= cnt + 1'b1;
    else if (dn & ~up)   cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/iot_riscv_regfile_sb.sv
// Integer register file with write-through bypass and per-register
// outstanding-write scoreboard for RAW stall generation at decode.
module iot_riscv_regfile_sb
  import iot_riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = NREGS_RV32I,
  parameter int NRP   = 2,
  parameter int PENDW = 2
) (
  input logic                   main_clk_i,
  input logic                   main_rst_i,
  iot_riscv_regfile_sb_if.slave bus
);
  // Arrays span all 32 encodable slots so a raw 5-bit index never selects
  // out of range; slots at or above NREGS are tied to zero.
  logic [XLEN-1:0]      rf  [REG_SLOTS];
  logic [PENDW-1:0]     cnt [REG_SLOTS];
  logic [REG_SLOTS-1:0] full_v, uflow_v;
  logic [NRP-1:0]       stall_v, illeg_v;
  logic                 rd_en, wb_live, iss_inc, sb_err_q;

  assign rd_en   = bus.id_ready_i & ~bus.id_flush_i;
  assign wb_live = bus.wb_we_i & idx_live(bus.wb_index_i, NREGS);

  assign bus.iss_full_o = full_v[bus.iss_rd_index_i];
  assign iss_inc = bus.iss_valid_i & rd_en & idx_live(bus.iss_rd_index_i, NREGS)
                 & ~bus.iss_full_o;

  assign rf[0]      = '0;
  assign cnt[0]     = '0;
  assign full_v[0]  = 1'b0;
  assign uflow_v[0] = 1'b0;
  assign bus.dbg_reg_o[XLEN-1:0] = '0;

  for (genvar r = 1; r < REG_SLOTS; r++) begin : g_reg
    if (r < NREGS) begin : g_live
      logic [XLEN-1:0] q;
      logic            hit, inc;

      assign hit = wb_live & (bus.wb_index_i == reg_idx_t'(r));
      assign inc = iss_inc & (bus.iss_rd_index_i == reg_idx_t'(r));

      always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) q <= '0;
        else if (hit)   q <= bus.wb_value_i;
      end

      iot_riscv_regfile_sb_cnt #(.PENDW(PENDW)) u_cnt (
        .clk_i (main_clk_i),
        .rst_i (main_rst_i),
        .inc   (inc),
        .dec   (hit),
        .cnt   (cnt[r]),
        .full  (full_v[r]),
        .uflow (uflow_v[r])
      );

      assign rf[r] = q;
      assign bus.dbg_reg_o[r*XLEN +: XLEN] = q;
    end else begin : g_none
      assign rf[r]      = '0;
      assign cnt[r]     = '0;
      assign full_v[r]  = 1'b0;
      assign uflow_v[r] = 1'b0;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    reg_idx_t        idx;
    logic            live, byp;
    logic [XLEN-1:0] val, q;

    assign idx  = bus.id_rs_index_i[p*REG_IDX_W +: REG_IDX_W];
    assign live = idx_live(idx, NREGS);
    assign byp  = bus.wb_we_i & (bus.wb_index_i == idx);
    assign val  = !live ? '0 : (byp ? bus.wb_value_i : rf[idx]);

    // A single pending write that is retiring right now is covered by the bypass.
    assign stall_v[p] = live & ((cnt[idx] > PENDW'(1)) | ((cnt[idx] == PENDW'(1)) & ~byp));
    assign illeg_v[p] = int'(idx) >= NREGS;

    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) q <= '0;
      else if (rd_en) q <= val;
    end

    assign bus.id_rs_value_o[p*XLEN +: XLEN] = q;
  end

  assign bus.id_stall_o   = |stall_v;
  assign bus.id_illegal_o = |illeg_v;

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i)    sb_err_q <= 1'b0;
    else if (|uflow_v) sb_err_q <= 1'b1;
  end

  assign bus.sb_err_o = sb_err_q;

endmodule

// File: tb/tb_iot_riscv_regfile_sb.sv
// Self-checking bench: an RV32I/2-port and an RV32E/3-port instance share
// one stimulus stream and are each checked against an array-based model.
module tb_iot_riscv_regfile_sb;
  import iot_riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_riscv_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRP(2)) ifa ();
  iot_riscv_regfile_sb_if #(.XLEN(32), .NREGS(16), .NRP(3)) ifb ();

  iot_riscv_regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2), .PENDW(2)) dut_a (
    .main_clk_i(clk), .main_rst_i(rst), .bus(ifa.slave));
  iot_riscv_regfile_sb #(.XLEN(32), .NREGS(16), .NRP(3), .PENDW(2)) dut_b (
    .main_clk_i(clk), .main_rst_i(rst), .bus(ifb.slave));

  logic        ready, flush, iss_valid, wb_we;
  logic [4:0]  rs [3];
  logic [4:0]  iss_rd, wb_idx;
  logic [31:0] wb_val;

  assign ifa.id_ready_i = ready;      assign ifb.id_ready_i = ready;
  assign ifa.id_flush_i = flush;      assign ifb.id_flush_i = flush;
  assign ifa.id_rs_index_i = {rs[1], rs[0]};
  assign ifb.id_rs_index_i = {rs[2], rs[1], rs[0]};
  assign ifa.iss_valid_i = iss_valid; assign ifb.iss_valid_i = iss_valid;
  assign ifa.iss_rd_index_i = iss_rd; assign ifb.iss_rd_index_i = iss_rd;
  assign ifa.wb_we_i = wb_we;         assign ifb.wb_we_i = wb_we;
  assign ifa.wb_index_i = wb_idx;     assign ifb.wb_index_i = wb_idx;
  assign ifa.wb_value_i = wb_val;     assign ifb.wb_value_i = wb_val;

  // Reference model, index d: 0 = RV32I instance, 1 = RV32E instance
  logic [31:0] m_reg [2][32];
  int          m_cnt [2][32];
  bit          m_err [2];
  logic [31:0] m_rv  [2][3];
  int n_chk = 0, n_fail = 0;

  function automatic int nr(int d); return (d == 0) ? 32 : 16; endfunction
  function automatic int np(int d); return (d == 0) ? 2 : 3; endfunction
  function automatic bit legal(int d, int i); return (i != 0) && (i < nr(d)); endfunction

  function automatic bit exp_stall(int d);
    for (int p = 0; p < np(d); p++) begin
      int i = int'(rs[p]);
      if (legal(d, i) && (m_cnt[d][i] > 1 ||
          (m_cnt[d][i] == 1 && !(wb_we && int'(wb_idx) == i)))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_illegal(int d);
    for (int p = 0; p < np(d); p++) if (int'(rs[p]) >= nr(d)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_full(int d);
    return legal(d, int'(iss_rd)) && m_cnt[d][iss_rd] == 3;
  endfunction

  function automatic logic [1023:0] exp_dbg(int d);
    logic [1023:0] v = '0;
    for (int r = 0; r < nr(d); r++) v[r*32 +: 32] = m_reg[d][r];
    return v;
  endfunction

  function automatic logic [31:0] obs_rv(int d, int p);
    if (d == 0) return ifa.id_rs_value_o[p*32 +: 32];
    return ifb.id_rs_value_o[p*32 +: 32];
  endfunction
  function automatic logic obs_stall(int d); return d ? ifb.id_stall_o : ifa.id_stall_o; endfunction
  function automatic logic obs_ill(int d);   return d ? ifb.id_illegal_o : ifa.id_illegal_o; endfunction
  function automatic logic obs_full(int d);  return d ? ifb.iss_full_o : ifa.iss_full_o; endfunction
  function automatic logic obs_err(int d);   return d ? ifb.sb_err_o : ifa.sb_err_o; endfunction
  function automatic logic [1023:0] obs_dbg(int d);
    return d ? {512'b0, ifb.dbg_reg_o} : ifa.dbg_reg_o;
  endfunction

  task automatic idle();
    ready = 0; flush = 0; iss_valid = 0; iss_rd = 0;
    wb_we = 0; wb_idx = 0; wb_val = 0;
    for (int p = 0; p < 3; p++) rs[p] = 0;
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 0;
      for (int r = 0; r < 32; r++) begin m_reg[d][r] = 0; m_cnt[d][r] = 0; end
      for (int p = 0; p < 3; p++) m_rv[d][p] = 0;
    end
  endtask

  // Advance one clock: model takes the architectural effect of the current inputs.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      int  rd = int'(iss_rd), w = int'(wb_idx);
      bit  inc = iss_valid && ready && !flush && legal(d, rd) && !exp_full(d);
      bit  wl  = wb_we && legal(d, w);
      bit  dec = wl && m_cnt[d][w] != 0;
      if (ready && !flush)
        for (int p = 0; p < np(d); p++) begin
          int i = int'(rs[p]);
          m_rv[d][p] = !legal(d, i) ? 32'h0 : ((wb_we && w == i) ? wb_val : m_reg[d][i]);
        end
      if (wl && m_cnt[d][w] == 0) m_err[d] = 1;
      if (!(inc && dec && rd == w)) begin
        if (inc) m_cnt[d][rd]++;
        if (dec) m_cnt[d][w]--;
      end
      if (wl) m_reg[d][w] = wb_val;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < np(d); p++) begin
        n_chk++;
        if (obs_rv(d, p) !== 32'h0) begin n_fail++;
          $display("FAIL reset_rv d%0d p%0d: got %h want 0", d, p, obs_rv(d, p)); end
      end
      n_chk++;
      if ({obs_stall(d), obs_ill(d), obs_full(d), obs_err(d)} !== 4'b0) begin n_fail++;
        $display("FAIL reset_flags d%0d: got %b want 0000", d,
                 {obs_stall(d), obs_ill(d), obs_full(d), obs_err(d)}); end
      n_chk++;
      if (obs_dbg(d) !== '0) begin n_fail++;
        $display("FAIL reset_dbg d%0d: got %h want 0", d, obs_dbg(d)); end
    end
    rst = 0; mreset();
    @(posedge clk); #1;
  endtask

  task automatic test_full_err();
    for (int k = 0; k < 4; k++) begin
      idle(); ready = 1; iss_valid = 1; iss_rd = 3;
      @(negedge clk);
      if (k == 3) for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs_full(d) !== 1'b1) begin n_fail++;
          $display("FAIL full_after3 d%0d: got %b want 1", d, obs_full(d)); end
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      idle(); wb_we = 1; wb_idx = 3; wb_val = 32'h100 + k;
      step();
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (obs_err(d) !== (k == 3)) begin n_fail++;
          $display("FAIL sb_err_wb%0d d%0d: got %b want %b", k, d, obs_err(d), k == 3); end
      end
    end
    idle(); iss_rd = 3; #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_full(d) !== 1'b0) begin n_fail++;
        $display("FAIL full_drained d%0d: got %b want 0", d, obs_full(d)); end
    end
  endtask

  task automatic test_write_read();
    idle(); wb_we = 1; wb_idx = 5; wb_val = 32'hDEADBEEF; step();
    idle(); ready = 1; rs[0] = 5; step();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_rv(d, 0) !== 32'hDEADBEEF) begin n_fail++;
        $display("FAIL read_x5 d%0d: got %h want deadbeef", d, obs_rv(d, 0)); end
    end
  endtask

  task automatic test_x0();
    logic [1023:0] v;
    idle(); wb_we = 1; wb_idx = 0; wb_val = 32'h1234; step();
    idle(); ready = 1; rs[0] = 0; rs[1] = 5; step();
    for (int d = 0; d < 2; d++) begin
      v = obs_dbg(d);
      n_chk++;
      if (v[31:0] !== 32'h0) begin n_fail++;
        $display("FAIL dbg_x0 d%0d: got %h want 0", d, v[31:0]); end
      n_chk++;
      if (obs_rv(d, 0) !== 32'h0) begin n_fail++;
        $display("FAIL read_x0 d%0d: got %h want 0", d, obs_rv(d, 0)); end
    end
  endtask

  task automatic test_raw_bypass();
    idle(); ready = 1; iss_valid = 1; iss_rd = 7; step();
    idle(); ready = 1; rs[1] = 7;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_stall(d) !== 1'b1) begin n_fail++;
        $display("FAIL raw_stall d%0d: got %b want 1", d, obs_stall(d)); end
    end
    wb_we = 1; wb_idx = 7; wb_val = 32'hA5A5A5A5; #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_stall(d) !== 1'b0) begin n_fail++;
        $display("FAIL bypass_nostall d%0d: got %b want 0", d, obs_stall(d)); end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_rv(d, 1) !== 32'hA5A5A5A5) begin n_fail++;
        $display("FAIL bypass_val d%0d: got %h want a5a5a5a5", d, obs_rv(d, 1)); end
    end
  endtask

  task automatic test_rv32e_illegal();
    logic [1023:0] before_b, v;
    idle(); ready = 1; rs[0] = 20;
    @(negedge clk);
    n_chk++;
    if (ifb.id_illegal_o !== 1'b1) begin n_fail++;
      $display("FAIL illegal_e: got %b want 1", ifb.id_illegal_o); end
    n_chk++;
    if (ifa.id_illegal_o !== 1'b0) begin n_fail++;
      $display("FAIL illegal_i: got %b want 0", ifa.id_illegal_o); end
    step();
    n_chk++;
    if (obs_rv(1, 0) !== 32'h0) begin n_fail++;
      $display("FAIL illegal_val: got %h want 0", obs_rv(1, 0)); end
    before_b = obs_dbg(1);
    idle(); wb_we = 1; wb_idx = 20; wb_val = 32'hCAFEF00D; step();
    n_chk++;
    if (obs_dbg(1) !== before_b) begin n_fail++;
      $display("FAIL x20_ignored_e: got %h want %h", obs_dbg(1), before_b); end
    v = obs_dbg(0);
    n_chk++;
    if (v[20*32 +: 32] !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL x20_written_i: got %h want cafef00d", v[20*32 +: 32]); end
  endtask

  task automatic test_same_cycle();
    idle(); ready = 1; iss_valid = 1; iss_rd = 9; step();
    idle(); ready = 1; iss_valid = 1; iss_rd = 9;
    wb_we = 1; wb_idx = 9; wb_val = 32'h99; step();
    idle(); rs[0] = 9;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_stall(d) !== 1'b1) begin n_fail++;
        $display("FAIL inc_dec_cnt1 d%0d: got stall %b want 1", d, obs_stall(d)); end
    end
    wb_we = 1; wb_idx = 9; wb_val = 32'h9A; step();
    idle(); rs[0] = 9; #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_stall(d) !== 1'b0) begin n_fail++;
        $display("FAIL x9_retired d%0d: got stall %b want 0", d, obs_stall(d)); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < 3; p++)
        rs[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      iss_valid = $urandom_range(0, 1);
      iss_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      wb_we     = $urandom_range(0, 1);
      wb_idx    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      wb_val    = $urandom;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if ({obs_stall(d), obs_ill(d), obs_full(d)} !== {exp_stall(d), exp_illegal(d), exp_full(d)}) begin
          n_fail++;
          $display("FAIL rnd_comb c%0d d%0d: got stall/ill/full %b want %b", c, d,
                   {obs_stall(d), obs_ill(d), obs_full(d)}, {exp_stall(d), exp_illegal(d), exp_full(d)});
        end
      end
      step();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < np(d); p++) begin
          n_chk++;
          if (obs_rv(d, p) !== m_rv[d][p]) begin n_fail++;
            $display("FAIL rnd_rv c%0d d%0d p%0d: got %h want %h", c, d, p, obs_rv(d, p), m_rv[d][p]); end
        end
        n_chk++;
        if (obs_err(d) !== m_err[d]) begin n_fail++;
          $display("FAIL rnd_err c%0d d%0d: got %b want %b", c, d, obs_err(d), m_err[d]); end
        n_chk++;
        if (obs_dbg(d) !== exp_dbg(d)) begin n_fail++;
          $display("FAIL rnd_dbg c%0d d%0d: got %h want %h", c, d, obs_dbg(d), exp_dbg(d)); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      idle(); ready = 1; iss_valid = 1; iss_rd = 4; step();
    end
    idle(); rs[0] = 4;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_stall(d) !== exp_stall(d)) begin n_fail++;
        $display("FAIL pre_rst_stall d%0d: got %b want %b", d, obs_stall(d), exp_stall(d)); end
    end
    #2 rst = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({obs_stall(d), obs_full(d), obs_err(d)} !== 3'b0) begin n_fail++;
        $display("FAIL async_rst_flags d%0d: got %b want 000", d, {obs_stall(d), obs_full(d), obs_err(d)}); end
      n_chk++;
      if (obs_dbg(d) !== '0) begin n_fail++;
        $display("FAIL async_rst_dbg d%0d: got %h want 0", d, obs_dbg(d)); end
      for (int p = 0; p < np(d); p++) begin
        n_chk++;
        if (obs_rv(d, p) !== 32'h0) begin n_fail++;
          $display("FAIL async_rst_rv d%0d p%0d: got %h want 0", d, p, obs_rv(d, p)); end
      end
    end
    @(negedge clk); rst = 0; mreset();
    @(posedge clk); #1;
    idle(); wb_we = 1; wb_idx = 4; wb_val = 32'h44; step();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (obs_err(d) !== 1'b1) begin n_fail++;
        $display("FAIL post_rst_wb_err d%0d: got %b want 1", d, obs_err(d)); end
    end
  endtask

  initial begin
    idle(); mreset();
    test_reset();
    test_full_err();
    test_write_read();
    test_x0();
    test_raw_bypass();
    test_rv32e_illegal();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
